fetch_ctrl: RTL and testbench

Instruction-fetch controller that sequences the program counter and arbitrates its next value between sequential increment, branch redirect and flush/exception redirect. It drives a request/acknowledge instruction-memory port, buffers the fetched word against downstream stalls, and generates the pipeline stall vector. It sits between the PC stage and the IF/ID register.

---
 rtl/fetch_ctrl_if.sv | 25 ++
 rtl/fetch_ctrl.sv | 166 ++++++++++++++++
 tb/tb_fetch_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/acknowledge bus between the fetch controller
// (master) and the instruction memory (slave).
interface fetch_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [INST_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: PC sequencing, branch/flush redirect, imem handshake,
// stall-tolerant hold buffer and pipeline stall vector. Optional: FETCH_TIMEOUT_EN.
module fetch_ctrl #(
  parameter int                 ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter int                 INST_W   = 32,
  parameter int                 TMO_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_req_id,
  input  logic              stall_req_ex,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              flush,
  input  logic [ADDR_W-1:0] new_pc,
  fetch_ctrl_if.master      imem,
  output logic [ADDR_W-1:0] pc,
  output logic [INST_W-1:0] inst,
  output logic              inst_valid,
  output logic [5:0]        stall
`ifdef FETCH_TIMEOUT_EN
  ,
  output logic              fetch_err
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    DRAIN
  } state_t;

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  if (TMO_W < 1) begin : g_tmo_w_check
    $error("fetch_ctrl: TMO_W must be at least 1");
  end

  state_t            state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] redirect_pc;
  logic [INST_W-1:0] hold_buf;
  logic [ADDR_W-1:0] target;
  logic              redirect;
  logic              stall_if;
  logic              ack;
  logic              tmo_abort;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    stall = 6'b000000;
    if (flush)             stall = 6'b000000;
    else if (stall_req_ex) stall = 6'b001111;
    else if (stall_req_id) stall = 6'b000111;
  end

  assign stall_if = stall[1];
  // A branch resolved while decode itself is stalled is not yet committed.
  assign redirect = flush | (branch_flag & ~stall[2]);

  always_comb begin
    target       = flush ? new_pc : branch_target;
    target[1:0]  = 2'b00;
  end

  assign imem.imem_req  = ((state == REQ) || (state == DRAIN)) && !tmo_abort;
  assign imem.imem_addr = fetch_pc;
  // An ack with no request outstanding (late ack after reset, spurious ack) is ignored.
  assign ack            = imem.imem_ack && imem.imem_req;

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      redirect_pc <= RESET_PC;
      pc          <= RESET_PC;
      inst        <= '0;
      inst_valid  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          state <= REQ;
          if (redirect) fetch_pc <= target;
        end

        REQ: begin
          if (redirect) begin
            inst_valid <= 1'b0;
            if (ack || !imem.imem_req) begin
              fetch_pc <= target;
            end else begin
              redirect_pc <= target;
              state       <= DRAIN;
            end
          end else if (ack) begin
            if (stall_if) begin
              state <= HOLD;
            end else begin
              pc         <= fetch_pc;
              inst       <= imem.imem_rdata;
              inst_valid <= 1'b1;
              fetch_pc   <= fetch_pc + PC_STEP;
            end
          end else if (!stall_if) begin
            inst_valid <= 1'b0;
          end
        end

        HOLD: begin
          if (redirect) begin
            fetch_pc   <= target;
            inst_valid <= 1'b0;
            state      <= REQ;
          end else if (!stall_if) begin
            pc         <= fetch_pc;
            inst       <= hold_buf;
            inst_valid <= 1'b1;
            fetch_pc   <= fetch_pc + PC_STEP;
            state      <= REQ;
          end
        end

        DRAIN: begin
          // The stale request must complete before the new address can be issued.
          if (ack || tmo_abort) begin
            fetch_pc <= redirect ? target : redirect_pc;
            state    <= REQ;
          end else if (redirect) begin
            redirect_pc <= target;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: hold_buf is pure datapath, always written before it is read, so it carries no reset.
  always_ff @(posedge clk) begin
    if ((state == REQ) && ack && !redirect && stall_if) hold_buf <= imem.imem_rdata;
  end

`ifdef FETCH_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt;

  // The cycle the counter sits at all-ones is the abort cycle: request dropped, error flagged.
  assign tmo_abort = (tmo_cnt == '1);
  assign fetch_err = tmo_abort;

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (tmo_abort || ack || redirect || !imem.imem_req) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  assign tmo_abort = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus randomized traffic
// against a transaction-level model of the fetch stage.
module tb_fetch_ctrl;

  typedef logic [97:0] bus_t;  // {imem_req, imem_addr, pc, inst, inst_valid}

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_req_id = 1'b0;
  logic        stall_req_ex = 1'b0;
  logic        branch_flag = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] branch_target = '0;
  logic [31:0] new_pc = '0;

  logic [31:0] pc, inst, w_pc, w_inst;
  logic        inst_valid, w_valid;
  logic [5:0]  stall, w_stall;
`ifdef FETCH_TIMEOUT_EN
  logic        fetch_err, w_err;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fetch_ctrl_if #(.ADDR_W(32), .INST_W(32)) imem ();
  fetch_ctrl_if #(.ADDR_W(32), .INST_W(32)) wmem ();

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, a[31:16]} + 32'h1357_9BDF;
  endfunction

  // Wrap-around instance: a memory that always acknowledges immediately.
  assign wmem.imem_ack   = 1'b1;
  assign wmem.imem_rdata = mem_word(wmem.imem_addr);

  fetch_ctrl #(.ADDR_W(32), .RESET_PC(32'h0000_0000), .INST_W(32), .TMO_W(4)) dut (
    .clk(clk), .rst(rst),
    .stall_req_id(stall_req_id), .stall_req_ex(stall_req_ex),
    .branch_flag(branch_flag), .branch_target(branch_target),
    .flush(flush), .new_pc(new_pc),
    .imem(imem),
    .pc(pc), .inst(inst), .inst_valid(inst_valid), .stall(stall)
`ifdef FETCH_TIMEOUT_EN
    , .fetch_err(fetch_err)
`endif
  );

  fetch_ctrl #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC), .INST_W(32), .TMO_W(4)) dut_w (
    .clk(clk), .rst(rst),
    .stall_req_id(stall_req_id), .stall_req_ex(stall_req_ex),
    .branch_flag(branch_flag), .branch_target(branch_target),
    .flush(flush), .new_pc(new_pc),
    .imem(wmem),
    .pc(w_pc), .inst(w_inst), .inst_valid(w_valid), .stall(w_stall)
`ifdef FETCH_TIMEOUT_EN
    , .fetch_err(w_err)
`endif
  );

  // ---------------- reference model (fetch-stage view) ----------------
  bit          m_live;    // first post-reset cycle has passed
  bit          m_buf;     // a fetched word waits for the stall to clear
  bit          m_drain;   // an abandoned request still awaits its ack
  logic [31:0] m_fpc, m_rpc, m_pc, m_inst;
  bit          m_valid;

  function automatic bit m_req();
    return m_live && !m_buf;
  endfunction

  function automatic logic [5:0] exp_stall();
    if (flush)        return 6'b000000;
    if (stall_req_ex) return 6'b001111;
    if (stall_req_id) return 6'b000111;
    return 6'b000000;
  endfunction

  function automatic bus_t exp_bus();
    return {m_req(), m_fpc, m_pc, m_inst, m_valid};
  endfunction

  function automatic bus_t obs_bus();
    return {imem.imem_req, imem.imem_addr, pc, inst, inst_valid};
  endfunction

  task automatic model_step();
    bit          busy, rd, got;
    logic [31:0] tgt;
    if (rst) begin
      m_live = 0; m_buf = 0; m_drain = 0;
      m_fpc = 32'h0; m_rpc = 32'h0; m_pc = 32'h0; m_inst = 32'h0; m_valid = 0;
      return;
    end
    busy = !flush && (stall_req_id || stall_req_ex);
    rd   = flush || (branch_flag && !(stall_req_id || stall_req_ex));
    tgt  = flush ? new_pc : branch_target;
    tgt  = tgt & 32'hFFFF_FFFC;
    got  = imem.imem_ack && m_req();
    if (!m_live) begin
      m_live = 1;
      if (rd) m_fpc = tgt;
    end else if (m_buf) begin
      if (rd) begin
        m_buf = 0; m_fpc = tgt; m_valid = 0;
      end else if (!busy) begin
        m_buf = 0; m_pc = m_fpc; m_inst = mem_word(m_fpc); m_valid = 1; m_fpc = m_fpc + 4;
      end
    end else if (m_drain) begin
      if (got) begin
        m_drain = 0; m_fpc = rd ? tgt : m_rpc;
      end else if (rd) begin
        m_rpc = tgt;
      end
    end else if (rd) begin
      m_valid = 0;
      if (got) m_fpc = tgt;
      else begin m_drain = 1; m_rpc = tgt; end
    end else if (got) begin
      if (busy) m_buf = 1;
      else begin m_pc = m_fpc; m_inst = mem_word(m_fpc); m_valid = 1; m_fpc = m_fpc + 4; end
    end else if (!busy) begin
      m_valid = 0;
    end
  endtask

  // ---------------- stimulus primitives ----------------
  task automatic drive(input bit sid, input bit sex, input bit br, input logic [31:0] bt,
                       input bit fl, input logic [31:0] np, input bit ack);
    @(negedge clk);
    stall_req_id    = sid;
    stall_req_ex    = sex;
    branch_flag     = br;
    branch_target   = bt;
    flush           = fl;
    new_pc          = np;
    imem.imem_ack   = ack;
    imem.imem_rdata = ack ? mem_word(m_fpc) : $urandom;
    #1;
  endtask

  task automatic idle(input bit ack);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, ack);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    idle(1'b0); tick();
    idle(1'b1); tick();
    n_checks++;
    if (obs_bus() !== {1'b0, 32'h0, 32'h0, 32'h0, 1'b0}) begin
      n_errors++; $display("FAIL reset_outputs: got %h expected %h", obs_bus(), {1'b0, 32'h0, 32'h0, 32'h0, 1'b0});
    end
    n_checks++;
    if (stall !== 6'b000000) begin
      n_errors++; $display("FAIL reset_stall: got %b expected 000000", stall);
    end
    n_checks++;
    if ({wmem.imem_req, wmem.imem_addr, w_pc, w_valid} !== {1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0}) begin
      n_errors++; $display("FAIL reset_wrap_inst: req=%b addr=%h pc=%h valid=%b", wmem.imem_req, wmem.imem_addr, w_pc, w_valid);
    end
    rst = 1'b0;
    idle(1'b0); tick();
    n_checks++;
    if ({imem.imem_req, imem.imem_addr, inst_valid} !== {1'b1, 32'h0, 1'b0}) begin
      n_errors++; $display("FAIL first_request: got req=%b addr=%h valid=%b expected req=1 addr=0 valid=0", imem.imem_req, imem.imem_addr, inst_valid);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      idle(1'b1); tick();
      n_checks++;
      if (obs_bus() !== {1'b1, 32'(4 * (i + 1)), 32'(4 * i), mem_word(32'(4 * i)), 1'b1}) begin
        n_errors++; $display("FAIL back_to_back[%0d]: got %h expected %h", i, obs_bus(), {1'b1, 32'(4 * (i + 1)), 32'(4 * i), mem_word(32'(4 * i)), 1'b1});
      end
    end
  endtask

  task automatic test_stall_ex();
    bus_t frozen;
    frozen = {1'b0, 32'h10, 32'hC, mem_word(32'hC), 1'b1};
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, i == 0);
      n_checks++;
      if (stall !== 6'b001111) begin
        n_errors++; $display("FAIL stall_ex_vector[%0d]: got %b expected 001111", i, stall);
      end
      tick();
      n_checks++;
      if (obs_bus() !== frozen) begin
        n_errors++; $display("FAIL stall_ex_hold[%0d]: got %h expected %h", i, obs_bus(), frozen);
      end
    end
    idle(1'b0); tick();
    n_checks++;
    if (obs_bus() !== {1'b1, 32'h14, 32'h10, mem_word(32'h10), 1'b1}) begin
      n_errors++; $display("FAIL stall_ex_release: got %h expected %h", obs_bus(), {1'b1, 32'h14, 32'h10, mem_word(32'h10), 1'b1});
    end
  endtask

  task automatic test_drain_branch();
    drive(1'b0, 1'b0, 1'b1, 32'h103, 1'b0, 32'h0, 1'b0); tick();
    n_checks++;
    if ({imem.imem_req, imem.imem_addr, inst_valid} !== {1'b1, 32'h14, 1'b0}) begin
      n_errors++; $display("FAIL drain_old_addr: got req=%b addr=%h valid=%b expected req=1 addr=14 valid=0", imem.imem_req, imem.imem_addr, inst_valid);
    end
    idle(1'b1); tick();
    n_checks++;
    if ({imem.imem_req, imem.imem_addr, inst_valid} !== {1'b1, 32'h100, 1'b0}) begin
      n_errors++; $display("FAIL drain_discard: got req=%b addr=%h valid=%b expected req=1 addr=100 valid=0", imem.imem_req, imem.imem_addr, inst_valid);
    end
    idle(1'b1); tick();
    n_checks++;
    if (obs_bus() !== {1'b1, 32'h104, 32'h100, mem_word(32'h100), 1'b1}) begin
      n_errors++; $display("FAIL drain_target_fetch: got %h expected %h", obs_bus(), {1'b1, 32'h104, 32'h100, mem_word(32'h100), 1'b1});
    end
  endtask

  task automatic test_flush_branch();
    drive(1'b1, 1'b0, 1'b1, 32'h200, 1'b1, 32'h182, 1'b1);
    n_checks++;
    if (stall !== 6'b000000) begin
      n_errors++; $display("FAIL flush_stall: got %b expected 000000", stall);
    end
    tick();
    n_checks++;
    if ({imem.imem_req, imem.imem_addr, inst_valid} !== {1'b1, 32'h180, 1'b0}) begin
      n_errors++; $display("FAIL flush_wins: got req=%b addr=%h valid=%b expected req=1 addr=180 valid=0", imem.imem_req, imem.imem_addr, inst_valid);
    end
    drive(1'b1, 1'b0, 1'b1, 32'h300, 1'b0, 32'h0, 1'b0);
    n_checks++;
    if (stall !== 6'b000111) begin
      n_errors++; $display("FAIL id_stall: got %b expected 000111", stall);
    end
    tick();
    idle(1'b1); tick();
    n_checks++;
    if (obs_bus() !== {1'b1, 32'h184, 32'h180, mem_word(32'h180), 1'b1}) begin
      n_errors++; $display("FAIL branch_ignored: got %h expected %h", obs_bus(), {1'b1, 32'h184, 32'h180, mem_word(32'h180), 1'b1});
    end
  endtask

  task automatic test_reset_mid_wait();
    idle(1'b0); tick();
    rst = 1'b1;
    idle(1'b0); tick();
    n_checks++;
    if (obs_bus() !== {1'b0, 32'h0, 32'h0, 32'h0, 1'b0}) begin
      n_errors++; $display("FAIL mid_reset: got %h expected %h", obs_bus(), {1'b0, 32'h0, 32'h0, 32'h0, 1'b0});
    end
    rst = 1'b0;
    idle(1'b1); tick();
    n_checks++;
    if ({imem.imem_req, imem.imem_addr, inst_valid} !== {1'b1, 32'h0, 1'b0}) begin
      n_errors++; $display("FAIL late_ack_ignored: got req=%b addr=%h valid=%b expected req=1 addr=0 valid=0", imem.imem_req, imem.imem_addr, inst_valid);
    end
  endtask

  task automatic test_wrap();
    rst = 1'b1;
    idle(1'b0); tick();
    rst = 1'b0;
    idle(1'b0); tick();
    n_checks++;
    if ({wmem.imem_req, wmem.imem_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
      n_errors++; $display("FAIL wrap_first: got req=%b addr=%h expected req=1 addr=fffffffc", wmem.imem_req, wmem.imem_addr);
    end
    idle(1'b0); tick();
    n_checks++;
    if ({wmem.imem_addr, w_pc, w_inst, w_valid} !== {32'h0, 32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC), 1'b1}) begin
      n_errors++; $display("FAIL wrap_zero: got addr=%h pc=%h inst=%h valid=%b expected addr=0 pc=fffffffc", wmem.imem_addr, w_pc, w_inst, w_valid);
    end
    idle(1'b0); tick();
    n_checks++;
    if ({wmem.imem_addr, w_pc} !== {32'h4, 32'h0}) begin
      n_errors++; $display("FAIL wrap_next: got addr=%h pc=%h expected addr=4 pc=0", wmem.imem_addr, w_pc);
    end
  endtask

`ifdef FETCH_TIMEOUT_EN
  task automatic test_timeout();
    rst = 1'b1;
    idle(1'b0); tick();
    rst = 1'b0;
    idle(1'b0); tick();
    for (int i = 0; i < 15; i++) begin
      idle(1'b0); tick();
      n_checks++;
      if ({imem.imem_req, fetch_err} !== ((i == 14) ? 2'b01 : 2'b10)) begin
        n_errors++; $display("FAIL timeout_wait[%0d]: got req=%b err=%b", i, imem.imem_req, fetch_err);
      end
    end
    idle(1'b0); tick();
    n_checks++;
    if ({imem.imem_req, imem.imem_addr, fetch_err} !== {1'b1, 32'h0, 1'b0}) begin
      n_errors++; $display("FAIL timeout_retry: got req=%b addr=%h err=%b expected req=1 addr=0 err=0", imem.imem_req, imem.imem_addr, fetch_err);
    end
  endtask
`endif

  task automatic test_random();
    bit          sid, sex, br, fl, ack;
    logic [31:0] bt, np;
    rst = 1'b1;
    idle(1'b0); tick();
    rst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 999) < 4);
      sid = ($urandom_range(0, 99) < 15);
      sex = ($urandom_range(0, 99) < 15);
      br  = ($urandom_range(0, 99) < 10);
      fl  = ($urandom_range(0, 99) < 5);
      bt  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : $urandom;
      np  = $urandom;
      ack = m_req() ? ($urandom_range(0, 99) < 55) : ($urandom_range(0, 99) < 5);
      drive(sid, sex, br, bt, fl, np, ack);
      n_checks++;
      if (stall !== exp_stall()) begin
        n_errors++; $display("FAIL rand_stall[%0d]: got %b expected %b", c, stall, exp_stall());
      end
      tick();
      n_checks++;
      if (obs_bus() !== exp_bus()) begin
        n_errors++; $display("FAIL rand_outputs[%0d]: got %h expected %h", c, obs_bus(), exp_bus());
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    imem.imem_ack   = 1'b0;
    imem.imem_rdata = '0;
    test_reset();
    test_back_to_back();
    test_stall_ex();
    test_drain_branch();
    test_flush_branch();
    test_reset_mid_wait();
    test_wrap();
`ifdef FETCH_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
